// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_pkg
// Description : Shared types for the commit-stream debug controller:
//               FSM states, halt causes and the buffered commit record.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EBREAK  = 3'd1,
    CAUSE_INVALID = 3'd2,
    CAUSE_HOST    = 3'd3,
    CAUSE_STEP    = 3'd4
  } cause_t;

  // One retired instruction as seen by the debug sink (104 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        brk;
    logic        ivd;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

endpackage
`default_nettype wire

// File: rtl/dbg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dbg_fifo
// Description : Synchronous FIFO of commit records. Head entry is read
//               straight from the storage registers; no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_fifo
  import dbg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rec_t push_rec,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_rec;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/dbg_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbg_commit_ctrl
// Description : Buffers retired-instruction records for the debug sink and
//               runs the run/step/drain/halted control of the core.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_commit_ctrl
  import dbg_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [31:0]       commit_pc,
  input  logic [31:0]       commit_inst,
  input  logic              commit_gpr_wen,
  input  logic [4:0]        commit_gpr_waddr,
  input  logic [31:0]       commit_gpr_wdata,
  input  logic              commit_brk,
  input  logic              commit_ivd,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [31:0]       dbg_pc,
  output logic [31:0]       dbg_inst,
  output logic              dbg_gpr_wen,
  output logic [4:0]        dbg_gpr_waddr,
  output logic [31:0]       dbg_gpr_wdata,
  output logic              dbg_brk,
  output logic              dbg_ivd,
  input  logic              halt_req,
  input  logic              resume,
  input  logic [STEP_W-1:0] step_count,
  output logic              core_halt,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [31:0]       instret
);

  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  cause_t            cause, cause_nxt;
  logic [STEP_W-1:0] remaining, remaining_nxt;
  logic              full, empty, accept, pop;
  rec_t              push_rec, head;

  assign commit_ready = !full && ((state == ST_RUN) ||
                                  ((state == ST_STEP) && (remaining != '0)));
  assign accept = commit_valid && commit_ready;
  assign pop    = !empty && dbg_ready;

  assign push_rec = '{pc: commit_pc, inst: commit_inst, gpr_wen: commit_gpr_wen,
                      gpr_waddr: commit_gpr_waddr, gpr_wdata: commit_gpr_wdata,
                      brk: commit_brk, ivd: commit_ivd};

  dbg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      cause     <= CAUSE_NONE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      cause     <= cause_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Next state: a halting instruction outranks step exhaustion, which outranks a host request.
  always_comb begin
    state_nxt     = state;
    cause_nxt     = cause;
    remaining_nxt = remaining;
    case (state)
      ST_RUN, ST_STEP: begin
        if (accept && (state == ST_STEP)) remaining_nxt = remaining - STEP_ONE;
        if (accept && commit_ivd) begin
          state_nxt = ST_DRAIN;
          cause_nxt = CAUSE_INVALID;
        end else if (accept && commit_brk) begin
          state_nxt = ST_DRAIN;
          cause_nxt = CAUSE_EBREAK;
        end else if (accept && (state == ST_STEP) && (remaining == STEP_ONE)) begin
          state_nxt = ST_DRAIN;
          cause_nxt = CAUSE_STEP;
        end else if (halt_req) begin
          state_nxt = ST_DRAIN;
          cause_nxt = CAUSE_HOST;
        end
      end
      ST_DRAIN: begin
        if (empty) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume) begin
          cause_nxt = CAUSE_NONE;
          if (step_count == '0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt     = ST_STEP;
            remaining_nxt = step_count;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)       instret <= '0;
    else if (accept) instret <= instret + 32'd1;
  end

  assign dbg_valid     = !empty;
  assign dbg_pc        = head.pc;
  assign dbg_inst      = head.inst;
  assign dbg_gpr_wen   = head.gpr_wen;
  assign dbg_gpr_waddr = head.gpr_waddr;
  assign dbg_gpr_wdata = head.gpr_wdata;
  assign dbg_brk       = head.brk;
  assign dbg_ivd       = head.ivd;

  assign core_halt  = (state == ST_DRAIN) || (state == ST_HALTED);
  assign halted     = (state == ST_HALTED);
  assign halt_cause = cause;

endmodule
`default_nettype wire
